// File: rtl/alu_core.sv
// Registered integer ALU for the execute stage: ten arithmetic/logic/shift/compare ops.
// Latency: 1 cycle, throughput 1 op/cycle.
// Backpressure: none; the result and zero flag hold while i_valid is low.
module alu_core #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [3:0]       i_op,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_res,
    output logic             o_zero
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_SLL  = 4'b0010;
    localparam logic [3:0] OP_SLT  = 4'b0011;
    localparam logic [3:0] OP_SLTU = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_OR   = 4'b1000;
    localparam logic [3:0] OP_AND  = 4'b1001;

    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   alu_res;
    logic [WIDTH-1:0]   res_d,   res_q;
    logic               zero_d,  zero_q;
    logic               valid_d, valid_q;

    // Only the low shift-amount bits of b matter; upper bits are ignored for shifts.
    assign shamt = i_b[SHAMT_W-1:0];

    always_comb begin
        alu_res = '0;
        unique case (i_op)
            OP_ADD:  alu_res = i_a + i_b;
            OP_SUB:  alu_res = i_a - i_b;
            OP_SLL:  alu_res = i_a << shamt;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (i_a < i_b)};
            OP_XOR:  alu_res = i_a ^ i_b;
            OP_SRL:  alu_res = i_a >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(i_a) >>> shamt);
            OP_OR:   alu_res = i_a | i_b;
            OP_AND:  alu_res = i_a & i_b;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        res_d   = res_q;
        zero_d  = zero_q;
        valid_d = i_valid;
        if (i_valid) begin
            res_d  = alu_res;
            zero_d = (alu_res == '0);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            res_q   <= '0;
            zero_q  <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            res_q   <= res_d;
            zero_q  <= zero_d;
            valid_q <= valid_d;
        end
    end

    assign o_res   = res_q;
    assign o_zero  = zero_q;
    assign o_valid = valid_q;

endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core: directed vectors plus randomized ops against a reference model.
module tb_alu_core;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [3:0]   in_op;
    logic         out_valid;
    logic [W-1:0] out_res;
    logic         out_zero;

    int n_checks = 0;
    int n_fail   = 0;

    alu_core #(.WIDTH(W), .SHAMT_W(5)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_valid (in_valid),
        .i_a     (in_a),
        .i_b     (in_b),
        .i_op    (in_op),
        .o_valid (out_valid),
        .o_res   (out_res),
        .o_zero  (out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model built from the operation definitions using plain arithmetic.
    function automatic logic [W-1:0] model(input logic [3:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        int unsigned sh;
        longint      sa, sb;
        logic [63:0] prod;
        logic [W-1:0] srl;
        sh = b % 32;
        sa = a[W-1] ? longint'(a) - 64'sh1_0000_0000 : longint'(a);
        sb = b[W-1] ? longint'(b) - 64'sh1_0000_0000 : longint'(b);
        srl = a / (32'd1 << sh);
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: begin
                prod = {32'd0, a} * (64'd1 << sh);
                return prod[W-1:0];
            end
            4'd3: return (sa < sb) ? 32'd1 : 32'd0;
            4'd4: return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
            4'd5: return a ^ b;
            4'd6: return srl;
            4'd7: return a[W-1] ? (srl | ~(32'hFFFF_FFFF / (32'd1 << sh))) : srl;
            4'd8: return a | b;
            4'd9: return a & b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic drive(input logic v, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b);
        in_valid = v;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        n_checks++;
        if (out_res !== 32'd0 || out_zero !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got res=%h zero=%b valid=%b expected res=0 zero=1 valid=0",
                     out_res, out_zero, out_valid);
        end
        rst_n = 1'b1;
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        n_checks++;
        if (out_valid !== 1'b0 || out_res !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_release_idle: got res=%h valid=%b expected res=0 valid=0",
                     out_res, out_valid);
        end
    endtask

    task automatic test_arith();
        logic [3:0]   ops[3];
        logic [W-1:0] as[3], bs[3], exps[3];
        ops[0] = 4'd0; as[0] = 32'hFFFF_FFFF; bs[0] = 32'd11; exps[0] = 32'h0000_000A;
        ops[1] = 4'd1; as[1] = 32'hFFFF_FFFF; bs[1] = 32'd11; exps[1] = 32'hFFFF_FFF4;
        ops[2] = 4'd0; as[2] = 32'h7FFF_FFFF; bs[2] = 32'd1;  exps[2] = 32'h8000_0000;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, ops[i], as[i], bs[i]);
            n_checks++;
            if (out_res !== exps[i] || out_valid !== 1'b1 || out_zero !== 1'b0) begin
                n_fail++;
                $display("FAIL arith[%0d]: got res=%h valid=%b zero=%b expected res=%h valid=1 zero=0",
                         i, out_res, out_valid, out_zero, exps[i]);
            end
        end
    endtask

    task automatic test_compare();
        logic [3:0]   ops[4];
        logic [W-1:0] as[4], bs[4], exps[4];
        ops[0] = 4'd3; as[0] = 32'hFFFF_FFFF; bs[0] = 32'd11; exps[0] = 32'd1;
        ops[1] = 4'd4; as[1] = 32'hFFFF_FFFF; bs[1] = 32'd11; exps[1] = 32'd0;
        ops[2] = 4'd3; as[2] = 32'd5;         bs[2] = 32'd5;  exps[2] = 32'd0;
        ops[3] = 4'd4; as[3] = 32'd5;         bs[3] = 32'd5;  exps[3] = 32'd0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, ops[i], as[i], bs[i]);
            n_checks++;
            if (out_res !== exps[i] || out_zero !== (exps[i] == 32'd0)) begin
                n_fail++;
                $display("FAIL compare[%0d]: got res=%h zero=%b expected res=%h zero=%b",
                         i, out_res, out_zero, exps[i], (exps[i] == 32'd0));
            end
        end
    endtask

    task automatic test_shift();
        logic [3:0]   ops[6];
        logic [W-1:0] as[6], bs[6], exps[6];
        ops[0] = 4'd2; as[0] = 32'hFFFF_FFFF; bs[0] = 32'd11;  exps[0] = 32'hFFFF_F800;
        ops[1] = 4'd6; as[1] = 32'hFFFF_FFFF; bs[1] = 32'd11;  exps[1] = 32'h001F_FFFF;
        ops[2] = 4'd7; as[2] = 32'hFFFF_FFFF; bs[2] = 32'd11;  exps[2] = 32'hFFFF_FFFF;
        ops[3] = 4'd2; as[3] = 32'h8000_0F01; bs[3] = 32'h20; exps[3] = 32'h8000_0F01;
        ops[4] = 4'd6; as[4] = 32'h8000_0F01; bs[4] = 32'h20; exps[4] = 32'h8000_0F01;
        ops[5] = 4'd7; as[5] = 32'h8000_0F01; bs[5] = 32'h20; exps[5] = 32'h8000_0F01;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, ops[i], as[i], bs[i]);
            n_checks++;
            if (out_res !== exps[i]) begin
                n_fail++;
                $display("FAIL shift[%0d]: got res=%h expected res=%h", i, out_res, exps[i]);
            end
        end
    endtask

    task automatic test_logic_reserved();
        logic [3:0]   ops[3];
        logic [W-1:0] exps[3];
        ops[0] = 4'd5; exps[0] = 32'hFFFF_FFF4;
        ops[1] = 4'd8; exps[1] = 32'hFFFF_FFFF;
        ops[2] = 4'd9; exps[2] = 32'h0000_000B;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, ops[i], 32'hFFFF_FFFF, 32'd11);
            n_checks++;
            if (out_res !== exps[i]) begin
                n_fail++;
                $display("FAIL logic[%0d]: got res=%h expected res=%h", i, out_res, exps[i]);
            end
        end
        for (int op = 10; op < 16; op++) begin
            drive(1'b1, 4'(op), 32'hFFFF_FFFF, 32'd11);
            n_checks++;
            if (out_res !== 32'd0 || out_zero !== 1'b1 || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL reserved_op%0d: got res=%h zero=%b valid=%b expected res=0 zero=1 valid=1",
                         op, out_res, out_zero, out_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] expq[$];
        logic [W-1:0] e;
        logic [3:0]   op;
        logic [W-1:0] a, b;
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 9));
            a  = $urandom;
            b  = $urandom;
            expq.push_back(model(op, a, b));
            drive(1'b1, op, a, b);
            e = expq.pop_front();
            n_checks++;
            if (out_res !== e || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: op=%0d got res=%h valid=%b expected res=%h valid=1",
                         i, op, out_res, out_valid, e);
            end
        end
    endtask

    task automatic test_hold();
        logic [W-1:0] held;
        logic         held_zero;
        drive(1'b1, 4'd0, 32'd1234, 32'd1);
        held      = 32'd1235;
        held_zero = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 4'd1, $urandom, $urandom);
            n_checks++;
            if (out_res !== held || out_zero !== held_zero || out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL hold[%0d]: got res=%h zero=%b valid=%b expected res=%h zero=%b valid=0",
                         i, out_res, out_zero, out_valid, held, held_zero);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] exp_res;
        logic         exp_zero;
        logic         v;
        logic [3:0]   op;
        logic [W-1:0] a, b;
        exp_res  = out_res;
        exp_zero = out_zero;
        for (int i = 0; i < 300; i++) begin
            v  = ($urandom_range(0, 3) != 0);
            op = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0:       a = 32'h8000_0000;
                1:       a = 32'hFFFF_FFFF;
                default: a = $urandom;
            endcase
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            if (v) begin
                exp_res  = model(op, a, b);
                exp_zero = (exp_res == 32'd0);
            end
            drive(v, op, a, b);
            n_checks++;
            if (out_res !== exp_res || out_zero !== exp_zero || out_valid !== v) begin
                n_fail++;
                $display("FAIL random[%0d]: op=%0d a=%h b=%h v=%b got res=%h zero=%b valid=%b expected res=%h zero=%b valid=%b",
                         i, op, a, b, v, out_res, out_zero, out_valid, exp_res, exp_zero, v);
            end
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 4'd8, 32'h00F0_0000, 32'h0000_0F00);
        rst_n = 1'b0;
        drive(1'b1, 4'd8, 32'hFFFF_FFFF, 32'd11);
        n_checks++;
        if (out_res !== 32'd0 || out_zero !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: got res=%h zero=%b valid=%b expected res=0 zero=1 valid=0",
                     out_res, out_zero, out_valid);
        end
        rst_n = 1'b1;
        drive(1'b0, 4'd8, 32'hFFFF_FFFF, 32'd11);
        n_checks++;
        if (out_res !== 32'd0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_idle: got res=%h valid=%b expected res=0 valid=0",
                     out_res, out_valid);
        end
        drive(1'b1, 4'd0, 32'hFFFF_FFFF, 32'd11);
        n_checks++;
        if (out_res !== 32'h0000_000A || out_valid !== 1'b1 || out_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL first_after_reset: got res=%h valid=%b zero=%b expected res=0000000a valid=1 zero=0",
                     out_res, out_valid, out_zero);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_op    = 4'd0;
        in_a     = '0;
        in_b     = '0;
        test_reset();
        test_arith();
        test_compare();
        test_shift();
        test_logic_reserved();
        test_back_to_back();
        test_hold();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
